uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/uart_tx.sv | 74 +++++++
 rtl/uart_tx_arb.sv | 112 +++++++++++
 tb/tb_uart_tx_arb.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults and arbiter state encoding.
package uart_pkg;

  localparam int NREQ_DEF       = 4;
  localparam int BAUD_DIV_DEF   = 2604;
  localparam int FRAME_BITS_DEF = 11;
  localparam int CNT_MIN_W      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first set req at or above ptr, wrapping.
module rr_arbiter import uart_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] lsb;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot    = NREQ'({req, req} >> ptr);
    lsb    = rot & (~rot + NREQ'(1));
    winner = NREQ'({lsb, lsb} << ptr >> NREQ);
    valid  = |req;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serialiser launched on a rising edge of tx_start.
module uart_tx import uart_pkg::*; #(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_start,
  input  logic [7:0] tx_din,
  output logic       txd,
  output logic       tx_active
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic          start_prev_q, start_prev_d;
  logic          active_q, active_d;
  logic [8:0]    shift_q, shift_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic          txd_q, txd_d;

  always_comb begin
    start_prev_d = tx_start;
    active_d     = active_q;
    shift_d      = shift_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    txd_d        = txd_q;
    if (!active_q) begin
      if (tx_start && !start_prev_q) begin
        active_d = 1'b1;
        shift_d  = {1'b1, tx_din};
        txd_d    = 1'b0;
        baud_d   = '0;
        bit_d    = '0;
      end
    end else if (baud_q == BW'(BAUD_DIV - 1)) begin
      baud_d = '0;
      // bit_q counts slots already on the line: 0 = start, 9 = stop.
      if (bit_q == 4'd9) begin
        active_d = 1'b0;
        txd_d    = 1'b1;
      end else begin
        txd_d   = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
        bit_d   = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      start_prev_q <= 1'b0;
      active_q     <= 1'b0;
      shift_q      <= '0;
      baud_q       <= '0;
      bit_q        <= '0;
      txd_q        <= 1'b1;
    end else begin
      start_prev_q <= start_prev_d;
      active_q     <= active_d;
      shift_q      <= shift_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      txd_q        <= txd_d;
    end
  end

  assign txd       = txd_q;
  assign tx_active = active_q;

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin byte arbiter feeding one UART transmitter, one frame at a time.
module uart_tx_arb import uart_pkg::*; #(
  parameter int NREQ       = NREQ_DEF,
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [7:0]        tx_din,
  output logic              busy
);

  localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FRAME_CYC = BAUD_DIV * FRAME_BITS;
  localparam int CNT_W     = ($clog2(FRAME_CYC) > CNT_MIN_W) ? $clog2(FRAME_CYC) : CNT_MIN_W;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_din_q, tx_din_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   arb_win;
  logic              arb_valid;
  logic [PW-1:0]     sel_idx;
  logic [7:0]        sel_data;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .winner (arb_win),
    .valid  (arb_valid)
  );

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_win[i]) begin
        sel_idx  = PW'(i);
        sel_data = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    tx_din_d   = tx_din_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d  = arb_win;
          tx_din_d = sel_data;
          ptr_d    = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + PW'(1);
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // Hold the line for the full reserved frame before re-arbitrating.
        if (cnt_q == CNT_W'(FRAME_CYC - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_din_q   <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
      busy_q     <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed bench for uart_tx_arb with the transmitter attached.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int BD   = 4;
  localparam int FB   = 11;
  localparam int K    = BD * FB;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic              tx_start;
  logic [7:0]        tx_din;
  logic              busy;
  logic              txd;
  logic              tx_active;

  uart_tx_arb #(.NREQ(NREQ), .BAUD_DIV(BD), .FRAME_BITS(FB)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_din   (tx_din),
    .busy     (busy)
  );

  uart_tx #(.BAUD_DIV(BD)) u_tx (
    .clk       (clk),
    .rstn      (rstn),
    .tx_start  (tx_start),
    .tx_din    (tx_din),
    .txd       (txd),
    .tx_active (tx_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic       mon_en = 1'b0;
  logic       busy_prev = 1'b0;
  logic [7:0] din_prev = 8'h00;
  always @(negedge clk) begin
    if (mon_en && busy && busy_prev) check("tx_din_stable_busy", {24'h0, tx_din}, {24'h0, din_prev});
    busy_prev = busy;
    din_prev  = tx_din;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_grant(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t tv[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   bc;
    int   gseen;
    int   ts;
    int   ts_prev;
    logic exp_bits [10];

    // Pointer is 1 entering the table (after the 0xA5 frame from requester 0).
    tv[0] = '{4'b0010, 32'h44332211, 4'b0010, 8'h22};
    tv[1] = '{4'b0011, 32'h88776655, 4'b0001, 8'h55};
    tv[2] = '{4'b0011, 32'hCCBBAA99, 4'b0010, 8'hAA};
    tv[3] = '{4'b1001, 32'h0F0E0D0C, 4'b1000, 8'h0F};
    tv[4] = '{4'b1001, 32'h1F1E1D1C, 4'b0001, 8'h1C};
    tv[5] = '{4'b0100, 32'h2F2E2D2C, 4'b0100, 8'h2E};
    tv[6] = '{4'b0110, 32'h3F3E3D3C, 4'b0010, 8'h3D};

    exp_bits = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rstn = 1'b0;
    req = '0;
    req_data = '0;
    repeat (3) tick();
    check("rst_grant", grant, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_din", tx_din, 0);
    check("rst_busy", busy, 0);
    check("rst_txd", txd, 1);

    rstn = 1'b1;
    gseen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (grant != '0 || busy) gseen++;
    end
    check("idle_noreq_quiet", gseen, 0);
    mon_en = 1'b1;

    // Single byte 0xA5 from requester 0, with a transient req from 2 during WAIT.
    req_data = 32'h000000A5;
    req = 4'b0001;
    wait_grant(4, ok);
    check("a5_grant_seen", ok, 1);
    check("a5_grant", grant, 4'b0001);
    check("a5_tx_din", tx_din, 8'hA5);
    check("a5_busy", busy, 1);
    check("a5_no_early_start", tx_start, 0);
    req = '0;
    tick();
    check("a5_grant_one_cycle", grant, 0);
    check("a5_tx_start", tx_start, 1);
    tick();
    check("a5_tx_start_one_cycle", tx_start, 0);
    bc = 3;
    gseen = 0;
    for (int i = 0; i < K + 10 && busy; i++) begin
      if (i == 10) req = 4'b0100;
      if (i == 20) req = '0;
      tick();
      if (busy) bc++;
      if (grant != '0) gseen++;
    end
    check("a5_busy_cycles", bc, K + 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (grant != '0) gseen++;
    end
    check("glitch_no_grant", gseen, 0);
    check("glitch_tx_din_kept", tx_din, 8'hA5);

    for (int v = 0; v < 7; v++) begin
      req_data = tv[v].data;
      req = tv[v].req;
      wait_grant(K + 10, ok);
      check($sformatf("tv%0d_grant_seen", v), ok, 1);
      check($sformatf("tv%0d_grant", v), grant, tv[v].exp_grant);
      check($sformatf("tv%0d_tx_din", v), tx_din, tv[v].exp_din);
      req = '0;
      tick();
      check($sformatf("tv%0d_grant_pulse", v), grant, 0);
      check($sformatf("tv%0d_tx_start", v), tx_start, 1);
      wait_idle(K + 10, ok);
      check($sformatf("tv%0d_idle", v), ok, 1);
    end

    // Pointer is 2 here; requester 2 wins, then reset aborts the frame at counter 20.
    req_data = 32'h33221100;
    req = 4'b0100;
    wait_grant(4, ok);
    check("abort_grant", grant, 4'b0100);
    req = '0;
    tick();
    check("abort_tx_start", tx_start, 1);
    repeat (20) tick();
    rstn = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_tx_start_low", tx_start, 0);
    check("abort_tx_din", tx_din, 8'h00);
    check("abort_grant_low", grant, 0);
    rstn = 1'b1;

    // All four requesters held: strict rotation from requester 0.
    req_data = 32'hD3D2D1D0;
    req = 4'b1111;
    ts_prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(K + 10, ok);
      check($sformatf("rr%0d_grant_seen", g), ok, 1);
      check($sformatf("rr%0d_grant", g), grant, 4'b0001 << (g % 4));
      check($sformatf("rr%0d_tx_din", g), tx_din, 8'hD0 + 8'(g % 4));
      tick();
      check($sformatf("rr%0d_tx_start", g), tx_start, 1);
      ts = cyc;
      if (g > 0) check($sformatf("rr%0d_start_spacing", g), ts - ts_prev, K + 2);
      ts_prev = ts;
    end
    req = '0;
    wait_idle(K + 10, ok);
    check("rr_idle", ok, 1);
    repeat (2) tick();
    check("ser_line_idle", {tx_active, txd}, 2'b01);

    // Serial line for 0x3C: start, LSB-first data, stop.
    req_data = 32'h0000003C;
    req = 4'b0001;
    wait_grant(4, ok);
    check("ser_grant", grant, 4'b0001);
    req = '0;
    ok = 1'b0;
    for (int i = 0; i < 3 * BD; i++) begin
      tick();
      if (!txd) begin
        ok = 1'b1;
        break;
      end
    end
    check("ser_start_seen", ok, 1);
    repeat (BD / 2) tick();
    for (int b = 0; b < 10; b++) begin
      if (b > 0) repeat (BD) tick();
      check($sformatf("ser_bit%0d", b), txd, exp_bits[b]);
    end
    wait_idle(K + 10, ok);
    check("ser_idle", ok, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
